// File: rtl/aes_pkg.sv
// AES SubBytes shared definitions: block geometry, byte type and engine FSM states.
package aes_pkg;

  localparam int unsigned NUM_BYTES = 16;
  localparam int unsigned BYTE_BITS = 8;

  typedef logic [BYTE_BITS-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/aes_sbox_fi.sv
// Combinational AES S-box with forward and inverse tables.
//   sel : byte to substitute
//   inv : 0 = forward S-box, 1 = inverse S-box
//   out : substituted byte
module aes_sbox_fi
  import aes_pkg::*;
(
  input  logic [7:0] sel,
  input  logic       inv,
  output logic [7:0] out
);

  // Entry k holds S(k); every 8-bit index is covered.
  localparam byte_t FWD_T [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam byte_t INV_T [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  assign out = inv ? INV_T[sel] : FWD_T[sel];

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes engine: processes a 128-bit state NUM_SBOX bytes per cycle.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : input handshake; in_inv and in_data sampled on transfer
//   out_valid/out_ready  : output handshake; out_data held stable while out_valid
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int unsigned NUM_SBOX = 4,
  parameter int unsigned BYTE_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_inv,
  input  logic [NUM_BYTES*BYTE_W-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_BYTES*BYTE_W-1:0]   out_data
);

  // Elaboration-time parameter legality.
  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
        NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_lanes
    $fatal(1, "sub_bytes_engine: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end
  if (BYTE_W != 8) begin : g_bad_byte_w
    $fatal(1, "sub_bytes_engine: BYTE_W must be 8");
  end

  localparam int unsigned BEATS     = (NUM_SBOX == 0) ? 1 : NUM_BYTES / NUM_SBOX;
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e                      fsm_q, fsm_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        mode_q, mode_d;
  byte_t [NUM_BYTES-1:0]       blk_q, blk_d;
  logic                        out_valid_q, out_valid_d;

  logic [3:0]                  lane_idx [NUM_SBOX];
  byte_t                       lane_in  [NUM_SBOX];
  byte_t                       lane_out [NUM_SBOX];

  // Lane l works on byte cnt*NUM_SBOX + l of the current beat.
  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_lane
    assign lane_idx[g] = 4'(32'(cnt_q) * NUM_SBOX + 32'(g));
    assign lane_in[g]  = blk_q[lane_idx[g]];

    aes_sbox_fi u_sbox (
      .sel (lane_in[g]),
      .inv (mode_q),
      .out (lane_out[g])
    );
  end

  // Ready while idle, or when the finished result leaves this cycle.
  always_comb begin
    in_ready = 1'b0;
    unique case (fsm_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    blk_d       = blk_q;
    out_valid_d = out_valid_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          blk_d  = in_data;
          mode_d = in_inv;
          cnt_d  = '0;
          fsm_d  = BUSY;
        end
      end
      BUSY: begin
        for (int unsigned l = 0; l < NUM_SBOX; l++) begin
          blk_d[lane_idx[l]] = lane_out[l];
        end
        if (cnt_q == LAST_BEAT) begin
          cnt_d       = '0;
          fsm_d       = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            blk_d  = in_data;
            mode_d = in_inv;
            cnt_d  = '0;
            fsm_d  = BUSY;
          end else begin
            fsm_d = IDLE;
          end
        end
      end
      default: begin
        fsm_d       = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      blk_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      blk_q       <= blk_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = blk_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine at NUM_SBOX = 1, 4 and 16, driven in lock-step.
module tb_sub_bytes_engine;

  localparam int NI = 3;

  localparam logic [7:0] FWD_T [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_T [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  // Hand-computed directed vectors.
  localparam logic [127:0] ZERO_V   = 128'h0;
  localparam logic [127:0] ALL63_V  = {16{8'h63}};
  localparam logic [127:0] EDGE_IN  = {8'hFF, {14{8'h00}}, 8'h53};
  localparam logic [127:0] EDGE_OUT = {8'h16, {14{8'h63}}, 8'hED};
  localparam logic [127:0] I16_IN   = {{15{8'h63}}, 8'h16};
  localparam logic [127:0] I16_OUT  = {{15{8'h00}}, 8'hFF};

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_inv;
  logic [127:0]   in_data;
  logic           out_ready;
  logic [NI-1:0]  ir;
  logic [NI-1:0]  ov;
  logic [127:0]   od [NI];

  int errors = 0;
  int checks = 0;

  sub_bytes_engine #(.NUM_SBOX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0])
  );
  sub_bytes_engine #(.NUM_SBOX(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1])
  );
  sub_bytes_engine #(.NUM_SBOX(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_lat(input int i);
    return (i == 0) ? 16 : (i == 1) ? 4 : 1;
  endfunction

  function automatic logic [127:0] sub_model(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      b = d[8*k +: 8];
      r[8*k +: 8] = inv ? INV_T[b] : FWD_T[b];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one block to all engines; returns just after the transfer edge.
  task automatic accept(input logic [127:0] d, input logic inv, input string tag);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_inv    = inv;
    #1;
    check({tag, "_rdy"}, 128'(ir), 128'(3'b111));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Track out_valid rise per engine over a bounded window while
  // driving junk that must not disturb the block in flight.
  task automatic wait_results(input logic [127:0] exp_d, input string tag);
    int lat [NI];
    for (int i = 0; i < NI; i++) lat[i] = 0;
    out_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_inv   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) if (ov[i] && lat[i] == 0) lat[i] = k;
    end
    in_valid = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_lat%0d", tag, i), 128'(lat[i]), 128'(exp_lat(i)));
      check($sformatf("%s_data%0d", tag, i), od[i], exp_d);
    end
    check({tag, "_vld"}, 128'(ov), 128'(3'b111));
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_drained"}, 128'(ov), 128'(0));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] d, input logic inv,
                           input logic [127:0] exp_d, input string tag);
    accept(d, inv, tag);
    wait_results(exp_d, tag);
    drain(tag);
  endtask

  initial begin
    logic [127:0] rd;
    logic [127:0] rd2;
    logic         rinv;
    int           seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", 128'(ov), 128'(0));
    for (int i = 0; i < NI; i++) check($sformatf("rst_data%0d", i), od[i], ZERO_V);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rdy", 128'(ir), 128'(3'b111));

    // Directed substitutions.
    run_block(ZERO_V,   1'b0, ALL63_V,  "fwd_zero");
    run_block(EDGE_IN,  1'b0, EDGE_OUT, "fwd_edge");
    run_block(EDGE_OUT, 1'b1, EDGE_IN,  "inv_edge");
    run_block(ALL63_V,  1'b1, ZERO_V,   "inv_63");
    run_block(I16_IN,   1'b1, I16_OUT,  "inv_16");

    // Random blocks against the table model.
    for (int r = 0; r < 6; r++) begin
      rd   = {$urandom, $urandom, $urandom, $urandom};
      rinv = 1'(r & 1);
      run_block(rd, rinv, sub_model(rd, rinv), $sformatf("rnd%0d", r));
    end

    // Backpressure in DONE, then simultaneous output and input transfer.
    rd  = {$urandom, $urandom, $urandom, $urandom};
    rd2 = {$urandom, $urandom, $urandom, $urandom};
    accept(rd, 1'b0, "bp");
    wait_results(sub_model(rd, 1'b0), "bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_inv   = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_vld%0d", c), 128'(ov), 128'(3'b111));
      check($sformatf("bp_hold_data%0d", c), od[1], sub_model(rd, 1'b0));
      check($sformatf("bp_hold_rdy%0d", c), 128'(ir), 128'(0));
    end
    @(negedge clk);
    in_valid  = 1'b1;
    in_inv    = 1'b1;
    in_data   = rd2;
    out_ready = 1'b1;
    #1;
    check("b2b_rdy", 128'(ir), 128'(3'b111));
    @(posedge clk);
    #1;
    check("b2b_vld_low", 128'(ov), 128'(0));
    wait_results(sub_model(rd2, 1'b1), "b2b");
    drain("b2b");

    // Reset during beat 2 of the NUM_SBOX=4 engine.
    accept(ALL63_V, 1'b1, "mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 128'(ov), 128'(0));
    for (int i = 0; i < NI; i++) check($sformatf("mid_rst_data%0d", i), od[i], ZERO_V);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mid_rst_rdy", 128'(ir), 128'(3'b111));
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ov != 3'b000) seen++;
    end
    check("mid_rst_stale", 128'(seen), 128'(0));
    out_ready = 1'b0;
    run_block(EDGE_IN, 1'b0, EDGE_OUT, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
